sysarray_skew_feeder: RTL and testbench

//  Upstream stage of sysarray. Accepts one row-parallel weight vector and one feature vector per beat.

---
 rtl/sysarray_pkg.sv | 27 ++
 rtl/skew_delay_line.sv | 41 ++++
 rtl/sysarray_skew_feeder.sv | 156 +++++++++++++++
 tb/tb_sysarray_skew_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_pkg.sv
// Shared types and defaults for the sysarray feeder slice.
//   SA_WL / SA_NUM   default element width and lane count
//   feeder_state_t   skew feeder control states
//   lane_beat_t      one lane beat: value, valid, end flag
//   cnt_width()      width of a down-counter able to hold n-1 (minimum 1)
package sysarray_pkg;

  localparam int unsigned SA_WL  = 32;
  localparam int unsigned SA_NUM = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [SA_WL-1:0] value;
    logic             valid;
    logic             endf;
  } lane_beat_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register carrying one lane beat, packed {value, valid, end}
// (same field order as lane_beat_t). DEPTH=0 degenerates to a wire.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears every stage)
//   ena       shift enable; 0 holds all stages
//   din       beat entering the line
//   dout      beat leaving the line, DEPTH cycles later
module skew_delay_line
  import sysarray_pkg::*;
#(
  parameter int unsigned WL    = SA_WL,
  parameter int unsigned DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [WL+1:0] din,
  output logic [WL+1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // a zero-depth line needs no clock, reset or enable
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ ena;
    assign dout = din;
  end else begin : g_regs
    logic [WL+1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else if (ena) begin
        stage[0] <= din;
        for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/sysarray_skew_feeder.sv
// Upstream skew stage for sysarray: takes one weight vector and one feature
// vector per beat, registers them, then delays lane i by a further i cycles so
// the array sees a diagonal wavefront. Tiles are framed by in_last and the skew
// is drained before the next tile is accepted.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ena                              global enable, 0 freezes all state
//   in_valid/in_ready                beat handshake
//   in_weight, in_feature, in_last   beat payload (lane i at [(i+1)*WL-1:i*WL])
//   weightvalue/weigthvalid/weigthend     skewed weight lanes
//   featurevalue/featurevalid/featureend  skewed feature lanes
//   tile_done                        pulse after lane NUM-1 emitted its end beat
//   busy                             control not idle
// Build option SKEW_FEEDER_PERF_EN adds tile_count/stall_count counters.
module sysarray_skew_feeder
  import sysarray_pkg::*;
#(
  parameter int unsigned WL  = SA_WL,
  parameter int unsigned NUM = SA_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WL*NUM-1:0] in_weight,
  input  logic [WL*NUM-1:0] in_feature,
  input  logic              in_last,
  output logic [WL*NUM-1:0] weightvalue,
  output logic [NUM-1:0]    weigthvalid,
  output logic [NUM-1:0]    weigthend,
  output logic [WL*NUM-1:0] featurevalue,
  output logic [NUM-1:0]    featurevalid,
  output logic [NUM-1:0]    featureend,
  output logic              tile_done,
  output logic              busy
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [15:0]       tile_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned CW = cnt_width(NUM);

  feeder_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;

  assign in_ready = ena & ((state == IDLE) | (state == STREAM));
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  // DRAIN is entered with NUM-1 and left as the count reaches 0, so in_ready
  // stays low for NUM-1 cycles; with a single lane there is nothing to drain.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            if (NUM > 1) begin
              state_nx = DRAIN;
              cnt_nx   = CW'(NUM - 1);
            end else begin
              state_nx = IDLE;
            end
          end else begin
            state_nx = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ena) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Input register: non-accept cycles inject an all-zero beat so bubbles and
  // the drain stay aligned per lane.
  logic [WL+1:0] w_in  [NUM];
  logic [WL+1:0] f_in  [NUM];
  logic [WL+1:0] w_out [NUM];
  logic [WL+1:0] f_out [NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        w_in[i] <= '0;
        f_in[i] <= '0;
      end
    end else if (ena) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        w_in[i] <= accept ? {in_weight[i*WL +: WL], 1'b1, in_last}  : '0;
        f_in[i] <= accept ? {in_feature[i*WL +: WL], 1'b1, in_last} : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    skew_delay_line #(.WL(WL), .DEPTH(g)) u_wdl (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .din  (w_in[g]),
      .dout (w_out[g])
    );
    skew_delay_line #(.WL(WL), .DEPTH(g)) u_fdl (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .din  (f_in[g]),
      .dout (f_out[g])
    );

    assign weightvalue[g*WL +: WL]  = w_out[g][WL+1:2] & {WL{w_out[g][1]}};
    assign weigthvalid[g]           = w_out[g][1];
    assign weigthend[g]             = w_out[g][0];
    assign featurevalue[g*WL +: WL] = f_out[g][WL+1:2] & {WL{f_out[g][1]}};
    assign featurevalid[g]          = f_out[g][1];
    assign featureend[g]            = f_out[g][0];
  end

  // Follows the last lane's end beat by one cycle; a reset clears the lines,
  // so an aborted tile never produces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tile_done <= 1'b0;
    else if (ena) tile_done <= w_out[NUM-1][0];
  end

`ifdef SKEW_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_count  <= '0;
      stall_count <= '0;
    end else begin
      if (ena & tile_done)      tile_count  <= tile_count + 16'd1;
      if (in_valid & ~in_ready) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sysarray_skew_feeder.sv
module tb_sysarray_skew_feeder;

  localparam int unsigned WL  = 32;
  localparam int unsigned NUM = 16;

  logic              clk = 1'b1;
  logic              rst, ena, in_valid, in_last;
  logic              in_ready, tile_done, busy;
  logic [WL*NUM-1:0] in_weight, in_feature, weightvalue, featurevalue;
  logic [NUM-1:0]    weigthvalid, weigthend, featurevalid, featureend;
`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0]       tile_count, stall_count;
`endif

  always #5 clk = ~clk;

  sysarray_skew_feeder #(.WL(WL), .NUM(NUM)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_weight    (in_weight),
    .in_feature   (in_feature),
    .in_last      (in_last),
    .weightvalue  (weightvalue),
    .weigthvalid  (weigthvalid),
    .weigthend    (weigthend),
    .featurevalue (featurevalue),
    .featurevalid (featurevalid),
    .featureend   (featureend),
    .tile_done    (tile_done),
    .busy         (busy)
`ifdef SKEW_FEEDER_PERF_EN
    ,
    .tile_count   (tile_count),
    .stall_count  (stall_count)
`endif
  );

  typedef struct {
    logic [WL-1:0] w;
    logic [WL-1:0] f;
    logic          e;
    int unsigned   due;
  } exp_t;

  exp_t        lq [NUM][$];
  int unsigned td_q[$];
  int unsigned ecnt = 0, drain_end = 0;
  bit          in_tile = 0;
  int          checks = 0, fails = 0;
  int          tiles_exp = 0, stalls_exp = 0;

  logic [WL*NUM-1:0] p_wv = '0, p_fv = '0;
  logic [NUM-1:0]    p_v = '0, p_e = '0;
  logic              p_td = 1'b0;

  task automatic chk(input string tag, input logic [WL*NUM-1:0] obs, input logic [WL*NUM-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return ena && !(ecnt < drain_end);
  endfunction

  task automatic check_outputs(input bit en);
    logic [WL*NUM-1:0] wv, fv;
    logic [NUM-1:0]    v, e;
    exp_t              b;
    if (en) begin
      wv = '0; fv = '0; v = '0; e = '0;
      p_td = 1'b0;
      if (td_q.size() > 0 && td_q[0] == ecnt) begin
        void'(td_q.pop_front());
        p_td = 1'b1;
        tiles_exp++;
      end
      for (int i = 0; i < NUM; i++) begin
        if (lq[i].size() > 0 && lq[i][0].due == ecnt) begin
          b = lq[i].pop_front();
          wv[i*WL +: WL] = b.w;
          fv[i*WL +: WL] = b.f;
          v[i] = 1'b1;
          e[i] = b.e;
          if (i == NUM-1 && b.e) td_q.push_back(ecnt + 1);
        end
      end
      p_wv = wv; p_fv = fv; p_v = v; p_e = e;
    end
    chk("weightvalue", weightvalue, p_wv);
    chk("featurevalue", featurevalue, p_fv);
    chk("weigthvalid", weigthvalid, p_v);
    chk("featurevalid", featurevalid, p_v);
    chk("weigthend", weigthend, p_e);
    chk("featureend", featureend, p_e);
    chk("tile_done", tile_done, p_td);
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step(output bit acc);
    bit en;
    #1;
    chk("in_ready", in_ready, exp_ready());
    chk("busy", busy, in_tile || (ecnt < drain_end));
    en  = ena;
    acc = in_valid && exp_ready();
    if (in_valid && !exp_ready()) stalls_exp++;
    if (acc) begin
      for (int i = 0; i < NUM; i++)
        lq[i].push_back('{w: in_weight[i*WL +: WL], f: in_feature[i*WL +: WL],
                          e: in_last, due: ecnt + 1 + int'(i)});
      if (in_last) begin
        drain_end = ecnt + NUM;
        in_tile   = 0;
      end else begin
        in_tile = 1;
      end
    end
    @(posedge clk);
    if (en) ecnt++;
    #1 check_outputs(en);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NUM; i++) begin
      in_weight[i*WL +: WL]  = $urandom;
      in_feature[i*WL +: WL] = $urandom;
    end
  endtask

  // Bubbles carry random payload to show it never leaks into the lanes.
  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      rand_payload();
      step(acc);
    end
  endtask

  task automatic beat(input logic [WL-1:0] wval, input bit last, input int tag);
    bit acc;
    in_valid  = 1'b1;
    in_last   = last;
    in_weight = {NUM{wval}};
    for (int i = 0; i < NUM; i++) in_feature[i*WL +: WL] = {16'(tag), 16'(i)};
    step(acc);
    if (!acc) begin
      fails++;
      $error("FAIL beat_accept: observed not accepted expected accepted");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM; i++) lq[i].delete();
    td_q.delete();
    drain_end = ecnt; in_tile = 0; tiles_exp = 0; stalls_exp = 0;
    p_wv = '0; p_fv = '0; p_v = '0; p_e = '0; p_td = 1'b0;
    #1 check_outputs(0);
    @(posedge clk);
    #1 check_outputs(0);
`ifdef SKEW_FEEDER_PERF_EN
    chk("tile_count_rst", tile_count, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int b, cyc;
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_weight = '0; in_feature = '0;

    // reset held 25ns, released with no traffic
    #25;
    check_outputs(0);
    rst = 1'b0;
    idle(2);

    // 32-beat tile of 1.0 weights
    for (int k = 0; k < 32; k++) beat(32'h3F80_0000, k == 31, k);
    idle(NUM + 4);

    // beat, bubble, last beat: bubble stays aligned on every lane
    beat(32'h3F80_0000, 1'b0, 100);
    idle(1);
    beat(32'h4000_0000, 1'b1, 101);
    idle(NUM + 4);

    // ena low for 3 cycles mid-stream
    b = 0; cyc = 0;
    while (b < 6 && cyc < 50) begin
      ena      = !(cyc >= 3 && cyc < 6);
      in_valid = 1'b1;
      in_last  = (b == 5);
      rand_payload();
      step(acc);
      if (acc) b++;
      cyc++;
    end
    ena = 1'b1;
    chk("stall_tile_beats", 32'(b), 32'd6);
    idle(NUM + 4);

    // single-beat tile
    beat(32'h4040_0000, 1'b1, 200);
    idle(NUM + 4);

    // reset while draining: tile is discarded
    for (int k = 0; k < 4; k++) beat(32'h4080_0000, k == 3, 300 + k);
    idle(3);
    pulse_reset();
    idle(NUM + 4);

    // random tile with random bubbles, then a back-to-back single beat
    b = 0; cyc = 0;
    while (b < 12 && cyc < 200) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_last  = (b == 11);
      rand_payload();
      step(acc);
      if (acc) b++;
      cyc++;
    end
    chk("rand_tile_beats", 32'(b), 32'd12);
    idle(NUM - 1);
    beat(32'h3F00_0000, 1'b1, 400);
    idle(NUM + 4);

`ifdef SKEW_FEEDER_PERF_EN
    chk("tile_count", tile_count, 16'(tiles_exp));
    chk("stall_count", stall_count, 16'(stalls_exp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
